// File: rtl/add_sub_16.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_16
// Brief    : 16-bit registered adder/subtractor on a Kogge-Stone carry tree.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] S,
    output logic        cout,
    output logic        ovf
);

    localparam int unsigned C_W = 16;

    logic [C_W-1:0] bb;
    logic [C_W-1:0] gen0, prop0;
    logic [C_W-1:0] gen1, gen2, gen3, gen4;
    logic [C_W-1:0] prop1_w;
    logic [C_W-1:0] prop2_w;
    logic [C_W-1:0] prop3_w;

    logic [C_W-1:0] s_d, s_q;
    logic           cout_d, cout_q;
    logic           ovf_d, ovf_q;

    // Bit-level generate/propagate with the carry-in folded into position 0.
    always_comb begin
        bb       = b ^ {C_W{cin}};
        prop0    = a ^ bb;
        gen0     = a & bb;
        gen0[0]  = (a[0] & bb[0]) | (prop0[0] & cin);
    end

    // Level 1, span 1: gray cell at bit 1, black cells from bit 2.
    assign gen1[0]       = gen0[0];
    assign prop1_w[1:0]  = 2'b00;
    generate
        for (genvar i = 1; i < C_W; i++) begin : g_lvl1
            assign gen1[i] = gen0[i] | (prop0[i] & gen0[i-1]);
            if (i >= 2) begin : g_black
                assign prop1_w[i] = prop0[i] & prop0[i-1];
            end
        end
    endgenerate

    // Level 2, span 2: gray cells at bits 2..3, black cells from bit 4.
    assign gen2[1:0]     = gen1[1:0];
    assign prop2_w[3:0]  = 4'b0000;
    generate
        for (genvar i = 2; i < C_W; i++) begin : g_lvl2
            assign gen2[i] = gen1[i] | (prop1_w[i] & gen1[i-2]);
            if (i >= 4) begin : g_black
                assign prop2_w[i] = prop1_w[i] & prop1_w[i-2];
            end
        end
    endgenerate

    // Level 3, span 4: gray cells at bits 4..7, black cells from bit 8.
    assign gen3[3:0]     = gen2[3:0];
    assign prop3_w[7:0]  = 8'h00;
    generate
        for (genvar i = 4; i < C_W; i++) begin : g_lvl3
            assign gen3[i] = gen2[i] | (prop2_w[i] & gen2[i-4]);
            if (i >= 8) begin : g_black
                assign prop3_w[i] = prop2_w[i] & prop2_w[i-4];
            end
        end
    endgenerate

    // Level 4, span 8: only group generates are needed, so all gray cells.
    assign gen4[7:0] = gen3[7:0];
    generate
        for (genvar i = 8; i < C_W; i++) begin : g_lvl4
            assign gen4[i] = gen3[i] | (prop3_w[i] & gen3[i-8]);
        end
    endgenerate

    // gen4[i] is the carry out of bit i, i.e. the carry into bit i+1.
    always_comb begin
        s_d    = prop0 ^ {gen4[C_W-2:0], cin};
        cout_d = gen4[C_W-1];
        ovf_d  = gen4[C_W-2] ^ gen4[C_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign S    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    // Low propagate bits of levels 1..3 feed no cell; tie them into nothing.
    logic w_unused_prop;
    assign w_unused_prop = ^{prop1_w[1:0], prop2_w[3:0], prop3_w[7:0]};

endmodule
`default_nettype wire

// File: tb/tb_add_sub_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_sub_16
// Brief    : Scoreboard bench for add_sub_16 with directed and random vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        cin;
    wire  [15:0] S;
    wire         cout, ovf;

    always #5 clk = ~clk;

    add_sub_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .S     (S),
        .cout  (cout),
        .ovf   (ovf)
    );

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    // Reference: plain integer arithmetic, signed overflow from the true range.
    function automatic exp_t model(input logic r, input logic [15:0] va, vb,
                                   input logic vc, input string nm);
        exp_t        e;
        int unsigned ua, ub, sum;
        int          sa, sb, res;
        e.name = nm;
        if (!r) begin
            e.s = 16'h0000; e.co = 1'b0; e.ov = 1'b0;
            return e;
        end
        ua  = int'(va);
        ub  = vc ? (int'(vb) ^ 32'h0000_ffff) : int'(vb);
        sum = ua + ub + (vc ? 1 : 0);
        e.s  = sum[15:0];
        e.co = sum[16];
        sa   = int'($signed(va));
        sb   = int'($signed(vb));
        res  = vc ? (sa - sb) : (sa + sb);
        e.ov = (res > 32767) || (res < -32768);
        return e;
    endfunction

    task automatic drive(input logic r, input logic [15:0] va, vb, input logic vc,
                         input logic [15:0] es, input logic eco, eov,
                         input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = r; a = va; b = vb; cin = vc;
        e.s = es; e.co = eco; e.ov = eov; e.name = nm;
        q.push_back(e);
    endtask

    task automatic drive_model(input logic r, input logic [15:0] va, vb,
                               input logic vc, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = r; a = va; b = vb; cin = vc;
        e = model(r, va, vb, vc, nm);
        q.push_back(e);
    endtask

    // Monitor: the result of every edge that had stimulus queued is checked.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (S === e.s && cout === e.co && ovf === e.ov)
                passed++;
            else
                $display("FAIL %s: got S=%h cout=%b ovf=%b, expected S=%h cout=%b ovf=%b",
                         e.name, S, cout, ovf, e.s, e.co, e.ov);
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rc, rr;
        rst_n = 1'b0; a = 16'hffff; b = 16'h0001; cin = 1'b0;

        drive(1'b0, 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, "rst_edge1");
        drive(1'b0, 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, "rst_edge2");
        drive(1'b1, 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "rst_release");

        drive(1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, "add_0000_0001");
        drive(1'b1, 16'h0069, 16'h0069, 1'b0, 16'h00d2, 1'b0, 1'b0, "add_0069_0069");
        drive(1'b1, 16'h0100, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b0, "add_0100_0000");
        drive(1'b1, 16'h0110, 16'h1001, 1'b0, 16'h1111, 1'b0, 1'b0, "add_0110_1001");
        drive(1'b1, 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_0001");
        drive(1'b1, 16'h55aa, 16'haa55, 1'b0, 16'hffff, 1'b0, 1'b0, "add_55aa_aa55");
        drive(1'b1, 16'h1010, 16'h0101, 1'b0, 16'h1111, 1'b0, 1'b0, "add_1010_0101");
        drive(1'b1, 16'h1010, 16'h0101, 1'b0, 16'h1111, 1'b0, 1'b0, "add_hold");

        drive(1'b1, 16'h0000, 16'h0001, 1'b1, 16'hffff, 1'b0, 1'b0, "sub_0000_0001");
        drive(1'b1, 16'h0069, 16'h0069, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_0069_0069");
        drive(1'b1, 16'h0100, 16'h0000, 1'b1, 16'h0100, 1'b1, 1'b0, "sub_0100_0000");
        drive(1'b1, 16'h0110, 16'h1001, 1'b1, 16'hf10f, 1'b0, 1'b0, "sub_0110_1001");
        drive(1'b1, 16'hffff, 16'h0001, 1'b1, 16'hfffe, 1'b1, 1'b0, "sub_ffff_0001");
        // 21930 - (-21931) = 43861 exceeds the signed range.
        drive(1'b1, 16'h55aa, 16'haa55, 1'b1, 16'hab55, 1'b0, 1'b1, "sub_55aa_aa55");
        drive(1'b1, 16'h1010, 16'h0101, 1'b1, 16'h0f0f, 1'b1, 1'b0, "sub_1010_0101");

        drive(1'b1, 16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_add_7fff_0001");
        drive(1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7fff, 1'b1, 1'b1, "ovf_sub_8000_0001");
        drive(1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_add_8000_8000");

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                drive(1'b1, 16'hffff, 16'hffff, 1'b0, 16'hfffe, 1'b1, 1'b0, "b2b_add_ffff");
            else
                drive(1'b1, 16'hffff, 16'hffff, 1'b1, 16'h0000, 1'b1, 1'b0, "b2b_sub_ffff");
        end
        drive(1'b1, 16'h8000, 16'h7fff, 1'b1, 16'h0001, 1'b1, 1'b1, "sub_8000_7fff");

        drive(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h0000, 1'b0, 1'b0, "rst_midstream");
        drive(1'b1, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "after_rst");

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rr = ($urandom_range(0, 49) != 0);
            drive_model(rr, ra, rb, rc, rr ? "rand" : "rand_rst");
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
